// File: rtl/candy_wb_arbiter.sv
// candy_wb_arbiter
//   Shares the single write port of the candy register file between the ALU
//   writeback path and the memory-load writeback path. It also keeps the
//   pending-write scoreboard that the issue stage uses for RAW/WAW checks.
//
// Ports
//   clk, reset                     clock; asynchronous active-low reset
//   alu_valid/ready/addr/data      ALU writeback request channel
//   mem_valid/ready/addr/data      load writeback request channel
//   rsv_valid, rsv_addr            destination reservation from issue
//   rsv_conflict                   reservation refused (target already pending)
//   chk_addr1/2, chk_busy1/2       source-operand pending lookups
//   rf_we, rf_waddr, rf_wdata      registered register-file write port
//   pending                        scoreboard bitmap, bit i = reg i outstanding
//   dbg_last_grant_mem             arbiter state: 1 = last grant went to MEM
//
// Handshake (both request channels): a transfer happens in any cycle where
// valid && ready. The requester holds valid/addr/data stable until accepted.
// ready is combinational from both valids and the arbiter state, and it is
// never high while its own valid is low.
module candy_wb_arbiter #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 4,
  parameter int NREGS  = 16  // must equal 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_conflict,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREGS-1:0]  pending,
  output logic              dbg_last_grant_mem
);

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_t;

  grant_t last_grant, last_grant_next;

  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;
  logic             wr_same_rsv;

  // Arbiter state register. Reset to MEM so the ALU wins the first conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= GNT_MEM;
    end else begin
      last_grant <= last_grant_next;
    end
  end

  // Round-robin grant: a lone requester always wins; on a conflict the
  // requester that did not win last time gets the port.
  always_comb begin
    alu_ready       = 1'b0;
    mem_ready       = 1'b0;
    last_grant_next = last_grant;
    if (alu_valid && (!mem_valid || last_grant == GNT_MEM)) begin
      alu_ready = 1'b1;
    end else if (mem_valid) begin
      mem_ready = 1'b1;
    end
    if (alu_ready) begin
      last_grant_next = GNT_ALU;
    end else if (mem_ready) begin
      last_grant_next = GNT_MEM;
    end
  end

  assign dbg_last_grant_mem = (last_grant == GNT_MEM);

  // Registered write stage: an accept in cycle N is written in cycle N+1.
  // Address/data hold their last values when no write is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= alu_ready || mem_ready;
      if (alu_ready) begin
        rf_waddr <= alu_addr;
        rf_wdata <= alu_data;
      end else if (mem_ready) begin
        rf_waddr <= mem_addr;
        rf_wdata <= mem_data;
      end
    end
  end

  // A reservation that lands on the register being written this cycle is
  // accepted: the old write retires and the new one takes its place, so the
  // bit must stay set rather than be refused.
  assign wr_same_rsv  = rf_we && (rf_waddr == rsv_addr);
  assign rsv_conflict = rsv_valid && pending[rsv_addr] && !wr_same_rsv;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (rsv_valid && !rsv_conflict) begin
      set_mask = NREGS'(1) << rsv_addr;
    end
    if (rf_we) begin
      clr_mask = NREGS'(1) << rf_waddr;
    end
  end

  // Clear happens on the same edge the register file captures the data;
  // set is applied after clear so it wins on a same-address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  assign chk_busy1 = pending[chk_addr1];
  assign chk_busy2 = pending[chk_addr2];

endmodule

// File: tb/tb_candy_wb_arbiter.sv
module tb_candy_wb_arbiter;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 16;

  logic              clk;
  logic              reset;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              rsv_valid;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_conflict;
  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              chk_busy1;
  logic              chk_busy2;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [NREGS-1:0]  pending;
  logic              dbg_last_grant_mem;

  int n_checks = 0;
  int n_fail   = 0;

  candy_wb_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NREGS (NREGS)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .alu_valid         (alu_valid),
    .alu_ready         (alu_ready),
    .alu_addr          (alu_addr),
    .alu_data          (alu_data),
    .mem_valid         (mem_valid),
    .mem_ready         (mem_ready),
    .mem_addr          (mem_addr),
    .mem_data          (mem_data),
    .rsv_valid         (rsv_valid),
    .rsv_addr          (rsv_addr),
    .rsv_conflict      (rsv_conflict),
    .chk_addr1         (chk_addr1),
    .chk_addr2         (chk_addr2),
    .chk_busy1         (chk_busy1),
    .chk_busy2         (chk_busy2),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .pending           (pending),
    .dbg_last_grant_mem(dbg_last_grant_mem)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_all();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    rsv_valid = 1'b0;
  endtask

  task automatic drive_alu(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    alu_valid = 1'b1;
    alu_addr  = a;
    alu_data  = d;
  endtask

  task automatic drive_mem(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_data  = d;
  endtask

  task automatic drive_rsv(input logic [ADDR_W-1:0] a);
    rsv_valid = 1'b1;
    rsv_addr  = a;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic exp_alu;
    logic [ADDR_W-1:0] exp_prev;

    reset     = 1'b0;
    alu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    chk_addr1 = '0;
    chk_addr2 = '0;

    repeat (3) @(posedge clk);
    sample();
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst_rf_wdata", 32'(rf_wdata), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_last_grant_mem", 32'(dbg_last_grant_mem), 32'd1);
    reset = 1'b1;

    // ---- single ALU write ----
    next_cycle();
    drive_alu(4'd3, 24'h00ABCD);
    sample();
    check("t1_alu_ready", 32'(alu_ready), 32'd1);
    check("t1_mem_ready_idle", 32'(mem_ready), 32'd0);
    next_cycle();
    idle_all();
    sample();
    check("t1_rf_we", 32'(rf_we), 32'd1);
    check("t1_rf_waddr", 32'(rf_waddr), 32'd3);
    check("t1_rf_wdata", 32'(rf_wdata), 32'h00ABCD);
    check("t1_alu_ready_no_valid", 32'(alu_ready), 32'd0);
    check("t1_pending_untouched", 32'(pending), 32'd0);
    next_cycle();
    sample();
    check("t1_rf_we_off", 32'(rf_we), 32'd0);
    check("t1_rf_waddr_hold", 32'(rf_waddr), 32'd3);
    check("t1_rf_wdata_hold", 32'(rf_wdata), 32'h00ABCD);

    // ---- single MEM write (leaves last grant = MEM) ----
    next_cycle();
    drive_mem(4'd9, 24'h999999);
    sample();
    check("t2_mem_ready", 32'(mem_ready), 32'd1);
    check("t2_alu_ready", 32'(alu_ready), 32'd0);
    next_cycle();
    idle_all();
    sample();
    check("t2_rf_we", 32'(rf_we), 32'd1);
    check("t2_rf_waddr", 32'(rf_waddr), 32'd9);
    check("t2_rf_wdata", 32'(rf_wdata), 32'h999999);

    // ---- both requesters valid for 4 cycles: ALU, MEM, ALU, MEM ----
    exp_prev = '0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      drive_alu(4'd1, 24'h111111);
      drive_mem(4'd2, 24'h222222);
      sample();
      exp_alu = (k % 2 == 0);
      check($sformatf("rr%0d_alu_ready", k), 32'(alu_ready), 32'(exp_alu));
      check($sformatf("rr%0d_mem_ready", k), 32'(mem_ready), 32'(!exp_alu));
      check($sformatf("rr%0d_both_ready", k), 32'(alu_ready && mem_ready), 32'd0);
      if (k > 0) begin
        check($sformatf("rr%0d_rf_we", k), 32'(rf_we), 32'd1);
        check($sformatf("rr%0d_rf_waddr", k), 32'(rf_waddr), 32'(exp_prev));
      end
      exp_prev = exp_alu ? 4'd1 : 4'd2;
    end
    next_cycle();
    idle_all();
    sample();
    check("rr_last_rf_we", 32'(rf_we), 32'd1);
    check("rr_last_rf_waddr", 32'(rf_waddr), 32'd2);
    check("rr_last_rf_wdata", 32'(rf_wdata), 32'h222222);

    // ---- reserve 5, load retires it ----
    next_cycle();
    drive_rsv(4'd5);
    chk_addr1 = 4'd5;
    chk_addr2 = 4'd0;
    sample();
    check("sb5_no_conflict", 32'(rsv_conflict), 32'd0);
    check("sb5_busy_before_edge", 32'(chk_busy1), 32'd0);
    next_cycle();
    idle_all();
    sample();
    check("sb5_pending", 32'(pending), 32'h0020);
    check("sb5_busy1", 32'(chk_busy1), 32'd1);
    check("sb5_busy2_other", 32'(chk_busy2), 32'd0);
    next_cycle();
    drive_mem(4'd5, 24'h555555);
    chk_addr2 = 4'd5;
    sample();
    check("sb5_mem_ready", 32'(mem_ready), 32'd1);
    check("sb5_busy1_accept", 32'(chk_busy1), 32'd1);
    check("sb5_busy2", 32'(chk_busy2), 32'd1);
    next_cycle();
    idle_all();
    sample();
    check("sb5_rf_we", 32'(rf_we), 32'd1);
    check("sb5_rf_waddr", 32'(rf_waddr), 32'd5);
    check("sb5_busy1_wcycle", 32'(chk_busy1), 32'd1);
    next_cycle();
    sample();
    check("sb5_busy1_cleared", 32'(chk_busy1), 32'd0);
    check("sb5_pending_cleared", 32'(pending), 32'd0);

    // ---- reserve 7, conflict, then reserve during its own write ----
    next_cycle();
    drive_rsv(4'd7);
    sample();
    next_cycle();
    sample();
    check("sb7_conflict", 32'(rsv_conflict), 32'd1);
    check("sb7_pending_set", 32'(pending), 32'h0080);
    next_cycle();
    rsv_valid = 1'b0;
    drive_alu(4'd7, 24'h777777);
    sample();
    check("sb7_pending_unchanged", 32'(pending), 32'h0080);
    check("sb7_alu_ready", 32'(alu_ready), 32'd1);
    next_cycle();
    idle_all();
    drive_rsv(4'd7);
    sample();
    check("sb7_wcycle_rf_waddr", 32'(rf_waddr), 32'd7);
    check("sb7_wcycle_no_conflict", 32'(rsv_conflict), 32'd0);
    next_cycle();
    idle_all();
    drive_rsv(4'd6);
    drive_alu(4'd7, 24'h070707);
    sample();
    check("sb7_set_wins", 32'(pending), 32'h0080);
    check("sb7_rf_we_off", 32'(rf_we), 32'd0);
    next_cycle();
    idle_all();
    sample();
    check("sb76_set6", 32'(pending), 32'h00C0);
    next_cycle();
    sample();
    check("sb7_cleared_6_kept", 32'(pending), 32'h0040);

    // ---- async reset mid-write with pending = 00F0 ----
    next_cycle();
    drive_rsv(4'd4);
    next_cycle();
    drive_rsv(4'd5);
    next_cycle();
    drive_rsv(4'd7);
    drive_mem(4'd4, 24'h444444);
    next_cycle();
    idle_all();
    sample();
    check("ar_pending_pre", 32'(pending), 32'h00F0);
    check("ar_rf_we_pre", 32'(rf_we), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_rf_we", 32'(rf_we), 32'd0);
    check("ar_pending", 32'(pending), 32'd0);
    check("ar_rf_waddr", 32'(rf_waddr), 32'd0);
    check("ar_rf_wdata", 32'(rf_wdata), 32'd0);
    sample();
    reset = 1'b1;
    next_cycle();
    drive_alu(4'd10, 24'hAAAAAA);
    drive_mem(4'd11, 24'hBBBBBB);
    sample();
    check("ar_first_alu_ready", 32'(alu_ready), 32'd1);
    check("ar_first_mem_ready", 32'(mem_ready), 32'd0);
    next_cycle();
    idle_all();
    sample();
    check("ar_first_rf_waddr", 32'(rf_waddr), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net: the directed sequence is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got no end, expected end");
    $fatal(1);
  end

endmodule
